// File: rtl/dbg_loader.sv
// rtl/dbg_loader.sv - UART byte-command debug loader driving a word-wide memory port
// Commands: W addr data, R addr, H (halt CPU), G (release CPU); multi-byte fields little-endian.
module dbg_loader #(
    parameter int RD_LAT    = 1,
    parameter bit BOOT_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        cpu_n_reset,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    input  logic [31:0] dbg_di,
    output logic        err
);

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_H   = 8'h48;
    localparam logic [7:0] CMD_G   = 8'h47;
    localparam logic [7:0] REPLY_K = 8'h4B;
    localparam logic [7:0] REPLY_E = 8'h45;
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

    typedef enum logic [2:0] {
        IDLE,
        ARG,
        WR,
        RD,
        TX
    } state_t;

    state_t      state_q,   state_d;
    logic        is_wr_q,   is_wr_d;
    logic [2:0]  cnt_q,     cnt_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] data_q,    data_d;
    logic [2:0]  lat_q,     lat_d;
    logic [31:0] txbuf_q,   txbuf_d;
    logic [2:0]  tx_left_q, tx_left_d;
    logic        cpu_q,     cpu_d;
    logic        err_q,     err_d;
    logic        last_arg;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            cnt_q     <= 3'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            lat_q     <= 3'd0;
            txbuf_q   <= 32'd0;
            tx_left_q <= 3'd0;
            cpu_q     <= ~BOOT_HALT;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            lat_q     <= lat_d;
            txbuf_q   <= txbuf_d;
            tx_left_q <= tx_left_d;
            cpu_q     <= cpu_d;
            err_q     <= err_d;
        end
    end

    assign last_arg = is_wr_q ? (cnt_q == 3'd7) : (cnt_q == 3'd3);

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        lat_d     = lat_q;
        txbuf_d   = txbuf_q;
        tx_left_d = tx_left_q;
        cpu_d     = cpu_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_W, CMD_R: begin
                            is_wr_d = (rx_data == CMD_W);
                            cnt_d   = 3'd0;
                            state_d = ARG;
                        end
                        CMD_H, CMD_G: begin
                            cpu_d     = (rx_data == CMD_G);
                            txbuf_d   = {24'd0, REPLY_K};
                            tx_left_d = 3'd1;
                            state_d   = TX;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ARG: begin
                if (rx_valid) begin
                    // Shift in from the top so the first byte ends up in bits [7:0].
                    if (!cnt_q[2]) begin
                        addr_d = {rx_data, addr_q[31:8]};
                    end else begin
                        data_d = {rx_data, data_q[31:8]};
                    end
                    cnt_d = cnt_q + 3'd1;
                    if (last_arg) begin
                        if (cpu_q) begin
                            err_d     = 1'b1;
                            txbuf_d   = {24'd0, REPLY_E};
                            tx_left_d = 3'd1;
                            state_d   = TX;
                        end else if (is_wr_q) begin
                            state_d = WR;
                        end else begin
                            lat_d   = 3'd0;
                            state_d = RD;
                        end
                    end
                end
            end
            WR: begin
                err_d     = rx_valid;
                txbuf_d   = {24'd0, REPLY_K};
                tx_left_d = 3'd1;
                state_d   = TX;
            end
            RD: begin
                err_d = rx_valid;
                if (lat_q == LAT_LAST) begin
                    txbuf_d   = dbg_di;
                    tx_left_d = 3'd4;
                    state_d   = TX;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            TX: begin
                err_d = rx_valid;
                if (tx_ready) begin
                    txbuf_d   = {8'd0, txbuf_q[31:8]};
                    tx_left_d = tx_left_q - 3'd1;
                    if (tx_left_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_mem_op  = (state_q == WR) || (state_q == RD);
    assign dbg_wren    = (state_q == WR) ? 4'hF : 4'h0;
    assign dbg_adr     = addr_q;
    assign dbg_do      = data_q;
    assign tx_valid    = (state_q == TX);
    assign tx_data     = txbuf_q[7:0];
    assign cpu_n_reset = cpu_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dbg_loader.sv
// tb/tb_dbg_loader.sv - directed bench for dbg_loader (RD_LAT=1/BOOT_HALT=1 and RD_LAT=3/BOOT_HALT=0)
module tb_dbg_loader;

    localparam logic [31:0] RDV  = 32'hC0202673;
    localparam logic [31:0] JUNK = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [7:0]  rx_data_a, rx_data_b;
    logic        rx_valid_a, rx_valid_b;
    logic        tx_ready_a, tx_ready_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_valid_a, tx_valid_b;
    logic        cpu_a, cpu_b;
    logic        dbg_mem_op_a, dbg_mem_op_b;
    logic [3:0]  dbg_wren_a, dbg_wren_b;
    logic [31:0] dbg_adr_a, dbg_adr_b, dbg_do_a, dbg_do_b;
    logic [31:0] dbg_di_a, dbg_di_b;
    logic        err_a, err_b;

    int total = 0;
    int bad   = 0;

    logic [7:0]  txq_a[$];
    logic [7:0]  txq_b[$];
    logic [31:0] wadr_q[$];
    logic [31:0] wdo_q[$];
    int          memop_a = 0, memop_b = 0, rd_wren_a = 0;
    int          errcnt_a = 0, stall_bad = 0;
    int          run_a = 0, run_b = 0;
    logic [31:0] rd_adr_a = 32'd0, rd_adr_b = 32'd0;
    logic        hold_a = 1'b0;
    logic [7:0]  hold_data_a = 8'd0;

    always #5 clk = ~clk;

    dbg_loader #(.RD_LAT(1), .BOOT_HALT(1'b1)) dut_a (
        .clk(clk), .n_reset(n_reset),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .cpu_n_reset(cpu_a), .dbg_mem_op(dbg_mem_op_a), .dbg_wren(dbg_wren_a),
        .dbg_adr(dbg_adr_a), .dbg_do(dbg_do_a), .dbg_di(dbg_di_a), .err(err_a)
    );

    dbg_loader #(.RD_LAT(3), .BOOT_HALT(1'b0)) dut_b (
        .clk(clk), .n_reset(n_reset),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .cpu_n_reset(cpu_b), .dbg_mem_op(dbg_mem_op_b), .dbg_wren(dbg_wren_b),
        .dbg_adr(dbg_adr_b), .dbg_do(dbg_do_b), .dbg_di(dbg_di_b), .err(err_b)
    );

    // Memory model: read data is only valid on the final cycle of a read access.
    assign dbg_di_a = (dbg_mem_op_a && run_a == 1) ? RDV : JUNK;
    assign dbg_di_b = (dbg_mem_op_b && run_b == 3) ? RDV : JUNK;

    always @(posedge clk) begin
        run_a <= dbg_mem_op_a ? run_a + 1 : 0;
        run_b <= dbg_mem_op_b ? run_b + 1 : 0;
    end

    always @(negedge clk) begin
        if (tx_valid_a && tx_ready_a) txq_a.push_back(tx_data_a);
        if (tx_valid_b && tx_ready_b) txq_b.push_back(tx_data_b);
        if (dbg_mem_op_a) begin
            memop_a++;
            if (dbg_wren_a == 4'hF) begin
                wadr_q.push_back(dbg_adr_a);
                wdo_q.push_back(dbg_do_a);
            end else begin
                rd_adr_a = dbg_adr_a;
                if (dbg_wren_a != 4'h0) rd_wren_a++;
            end
        end
        if (dbg_mem_op_b) begin
            memop_b++;
            rd_adr_b = dbg_adr_b;
        end
        if (err_a) errcnt_a++;
        if (hold_a && (!tx_valid_a || tx_data_a != hold_data_a)) stall_bad++;
        hold_a      = tx_valid_a && !tx_ready_a;
        hold_data_a = tx_data_a;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        rx_data_a  = b;
        rx_valid_a = 1'b1;
        step();
        rx_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        rx_data_b  = b;
        rx_valid_b = 1'b1;
        step();
        rx_valid_b = 1'b0;
    endtask

    task automatic send_w_a(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_a(w[8*i +: 8]);
    endtask

    task automatic send_w_b(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_b(w[8*i +: 8]);
    endtask

    task automatic wait_tx_a(input int n);
        for (int k = 0; k < 200 && txq_a.size() < n; k++) step();
    endtask

    task automatic wait_tx_b(input int n);
        for (int k = 0; k < 200 && txq_b.size() < n; k++) step();
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) step();
        total++; if (cpu_a !== 1'b0) begin bad++; $display("FAIL reset_cpu_a: got %b expected 0", cpu_a); end
        total++; if (cpu_b !== 1'b1) begin bad++; $display("FAIL reset_cpu_b: got %b expected 1", cpu_b); end
        total++; if ({tx_valid_a, tx_data_a} !== 9'd0) begin bad++; $display("FAIL reset_tx: got %b/%h expected 0/00", tx_valid_a, tx_data_a); end
        total++; if ({dbg_mem_op_a, dbg_wren_a, err_a} !== 6'd0) begin bad++; $display("FAIL reset_ctl: got %b expected 000000", {dbg_mem_op_a, dbg_wren_a, err_a}); end
        total++; if ({dbg_adr_a, dbg_do_a} !== 64'd0) begin bad++; $display("FAIL reset_bus: got %h/%h expected 0/0", dbg_adr_a, dbg_do_a); end
        n_reset = 1'b1;
        repeat (2) step();
        total++; if ({tx_valid_a, dbg_mem_op_a, cpu_a} !== 3'b000) begin bad++; $display("FAIL reset_idle: got %b expected 000", {tx_valid_a, dbg_mem_op_a, cpu_a}); end
    endtask

    task automatic test_boot();
        logic [31:0] bd [6];
        bd = '{32'h33, 32'h13, 32'h93, 32'h73, 32'h67, 32'h6F};
        memop_a = 0;
        wadr_q.delete();
        wdo_q.delete();
        for (int i = 0; i < 6; i++) begin
            txq_a.delete();
            send_a(8'h57);
            send_w_a(32'h00020000 + 32'(4 * i));
            send_w_a(bd[i]);
            wait_tx_a(1);
            total++; if (txq_a.size() !== 1 || txq_a[0] !== 8'h4B) begin bad++; $display("FAIL boot_reply%0d: got %0d bytes first %h expected 1 byte 4b", i, txq_a.size(), txq_a[0]); end
        end
        total++; if (wadr_q.size() !== 6 || memop_a !== 6) begin bad++; $display("FAIL boot_writes: got %0d writes %0d bus cycles expected 6/6", wadr_q.size(), memop_a); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (wadr_q[i] !== 32'h00020000 + 32'(4 * i) || wdo_q[i] !== bd[i]) begin
                bad++; $display("FAIL boot_write%0d: got %h/%h expected %h/%h", i, wadr_q[i], wdo_q[i], 32'h00020000 + 32'(4 * i), bd[i]);
            end
        end
        total++; if (cpu_a !== 1'b0) begin bad++; $display("FAIL boot_halted: got %b expected 0", cpu_a); end
        txq_a.delete();
        send_a(8'h47);
        wait_tx_a(1);
        total++; if (txq_a.size() !== 1 || txq_a[0] !== 8'h4B || cpu_a !== 1'b1) begin bad++; $display("FAIL boot_go: got %0d bytes %h cpu %b expected 1 byte 4b cpu 1", txq_a.size(), txq_a[0], cpu_a); end
    endtask

    task automatic test_readback();
        logic [7:0] exp_rb [4];
        exp_rb = '{8'h73, 8'h26, 8'h20, 8'hC0};
        txq_a.delete();
        send_a(8'h48);
        wait_tx_a(1);
        total++; if (txq_a[0] !== 8'h4B || cpu_a !== 1'b0) begin bad++; $display("FAIL rb_halt_a: got %h cpu %b expected 4b cpu 0", txq_a[0], cpu_a); end
        txq_a.delete();
        memop_a = 0;
        rd_wren_a = 0;
        send_a(8'h52);
        send_w_a(32'h0002000C);
        wait_tx_a(4);
        total++; if (memop_a !== 2 || rd_adr_a !== 32'h0002000C || rd_wren_a !== 0) begin bad++; $display("FAIL rb_bus_a: got %0d cycles adr %h wren hits %0d expected 2 0002000c 0", memop_a, rd_adr_a, rd_wren_a); end
        for (int i = 0; i < 4; i++) begin
            total++; if (txq_a[i] !== exp_rb[i]) begin bad++; $display("FAIL rb_byte_a%0d: got %h expected %h", i, txq_a[i], exp_rb[i]); end
        end
        txq_b.delete();
        send_b(8'h48);
        wait_tx_b(1);
        total++; if (txq_b[0] !== 8'h4B || cpu_b !== 1'b0) begin bad++; $display("FAIL rb_halt_b: got %h cpu %b expected 4b cpu 0", txq_b[0], cpu_b); end
        txq_b.delete();
        memop_b = 0;
        send_b(8'h52);
        send_w_b(32'h0002000C);
        wait_tx_b(4);
        total++; if (memop_b !== 4 || rd_adr_b !== 32'h0002000C) begin bad++; $display("FAIL rb_bus_b: got %0d cycles adr %h expected 4 0002000c", memop_b, rd_adr_b); end
        for (int i = 0; i < 4; i++) begin
            total++; if (txq_b[i] !== exp_rb[i]) begin bad++; $display("FAIL rb_byte_b%0d: got %h expected %h", i, txq_b[i], exp_rb[i]); end
        end
    endtask

    task automatic test_backpressure();
        txq_a.delete();
        stall_bad = 0;
        tx_ready_a = 1'b0;
        send_a(8'h52);
        send_w_a(32'h00020002);
        for (int k = 0; k < 20 && !tx_valid_a; k++) step();
        repeat (10) step();
        total++; if (txq_a.size() !== 0 || tx_valid_a !== 1'b1 || tx_data_a !== 8'h73) begin bad++; $display("FAIL bp_hold: got %0d bytes valid %b data %h expected 0 1 73", txq_a.size(), tx_valid_a, tx_data_a); end
        total++; if (rd_adr_a !== 32'h00020002) begin bad++; $display("FAIL bp_unaligned_adr: got %h expected 00020002", rd_adr_a); end
        tx_ready_a = 1'b1;
        step();
        tx_ready_a = 1'b0;
        repeat (10) step();
        tx_ready_a = 1'b1;
        wait_tx_a(4);
        total++; if (txq_a.size() !== 4 || {txq_a[0], txq_a[1], txq_a[2], txq_a[3]} !== 32'h732620C0) begin bad++; $display("FAIL bp_bytes: got %0d bytes %h%h%h%h expected 4 732620c0", txq_a.size(), txq_a[0], txq_a[1], txq_a[2], txq_a[3]); end
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_bad); end
    endtask

    task automatic test_errors();
        int e0;
        e0 = errcnt_a;
        txq_a.delete();
        send_a(8'h00);
        repeat (5) step();
        total++; if (errcnt_a - e0 !== 1 || txq_a.size() !== 0) begin bad++; $display("FAIL err_bad_cmd: got %0d pulses %0d bytes expected 1 0", errcnt_a - e0, txq_a.size()); end
        send_a(8'h47);
        wait_tx_a(1);
        txq_a.delete();
        memop_a = 0;
        e0 = errcnt_a;
        send_a(8'h57);
        send_w_a(32'h00020040);
        send_w_a(32'hA5A5A5A5);
        wait_tx_a(1);
        total++; if (memop_a !== 0 || txq_a[0] !== 8'h45 || errcnt_a - e0 !== 1) begin bad++; $display("FAIL err_w_running: got %0d cycles reply %h %0d pulses expected 0 45 1", memop_a, txq_a[0], errcnt_a - e0); end
        txq_a.delete();
        e0 = errcnt_a;
        tx_ready_a = 1'b0;
        send_a(8'h52);
        send_w_a(32'h00020000);
        send_a(8'h57);
        repeat (3) step();
        total++; if (tx_valid_a !== 1'b1 || tx_data_a !== 8'h45) begin bad++; $display("FAIL err_tx_kept: got valid %b data %h expected 1 45", tx_valid_a, tx_data_a); end
        tx_ready_a = 1'b1;
        wait_tx_a(1);
        repeat (3) step();
        total++; if (txq_a.size() !== 1 || txq_a[0] !== 8'h45 || errcnt_a - e0 !== 2) begin bad++; $display("FAIL err_during_tx: got %0d bytes %h %0d pulses expected 1 45 2", txq_a.size(), txq_a[0], errcnt_a - e0); end
    endtask

    task automatic test_reset_mid();
        memop_a = 0;
        txq_a.delete();
        send_a(8'h57);
        send_w_a(32'h00020020);
        n_reset = 1'b0;
        repeat (2) step();
        total++; if (cpu_a !== 1'b0 || tx_valid_a !== 1'b0) begin bad++; $display("FAIL mid_reset_state: got cpu %b valid %b expected 0 0", cpu_a, tx_valid_a); end
        n_reset = 1'b1;
        repeat (4) step();
        total++; if (memop_a !== 0 || txq_a.size() !== 0) begin bad++; $display("FAIL mid_reset_nowrite: got %0d cycles %0d bytes expected 0 0", memop_a, txq_a.size()); end
        wadr_q.delete();
        wdo_q.delete();
        send_a(8'h57);
        send_w_a(32'h00020020);
        send_w_a(32'h12345678);
        wait_tx_a(1);
        total++; if (wadr_q.size() !== 1 || wadr_q[0] !== 32'h00020020 || wdo_q[0] !== 32'h12345678 || txq_a[0] !== 8'h4B) begin bad++; $display("FAIL mid_reset_rewrite: got %0d writes %h/%h reply %h expected 1 00020020/12345678 4b", wadr_q.size(), wadr_q[0], wdo_q[0], txq_a[0]); end
    endtask

    initial begin
        rx_data_a  = 8'd0;
        rx_data_b  = 8'd0;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        tx_ready_a = 1'b1;
        tx_ready_b = 1'b1;
        n_reset    = 1'b0;
        test_reset();
        test_boot();
        test_readback();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
